// File: rtl/img_lut_pkg.sv
// img_lut_pkg: shared constants, pixel type and helpers for the dynamic pixel LUT.
// Consumers import img_lut_pkg::*.
package img_lut_pkg;

    localparam int PX_WIDTH_DEF = 10;
    localparam int CH_NUM_DEF   = 3;
    localparam int PIPE_DEPTH   = 2;

    typedef struct packed {
        logic [CH_NUM_DEF-1:0][PX_WIDTH_DEF-1:0] ch;
    } px_t;

    function automatic int ch_sel_w(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

endpackage

// File: rtl/img_lut_ram.sv
// img_lut_ram: simple dual-port table RAM, one write port, one enabled registered read port.
// A read that collides with a write to the same address returns the newly written value.
module img_lut_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 10
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/img_lut_dyn.sv
// img_lut_dyn: run-time loadable, double-buffered per-channel pixel LUT on an AXI4-Stream path.
// Define IMG_LUT_BYPASS_EN to add a per-beat bypass_i input that passes data through unmapped.
module img_lut_dyn
    import img_lut_pkg::*;
#(
    parameter int PX_WIDTH = PX_WIDTH_DEF,
    parameter int CH_NUM   = CH_NUM_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [CH_NUM*PX_WIDTH-1:0]  s_tdata_i,
    input  logic                        s_tvalid_i,
    output logic                        s_tready_o,
    input  logic                        s_tuser_i,
    input  logic                        s_tlast_i,
`ifdef IMG_LUT_BYPASS_EN
    input  logic                        bypass_i,
`endif
    output logic [CH_NUM*PX_WIDTH-1:0]  m_tdata_o,
    output logic                        m_tvalid_o,
    input  logic                        m_tready_i,
    output logic                        m_tuser_o,
    output logic                        m_tlast_o,
    input  logic                        wr_en_i,
    input  logic [ch_sel_w(CH_NUM)-1:0] wr_ch_i,
    input  logic [PX_WIDTH-1:0]         wr_addr_i,
    input  logic [PX_WIDTH-1:0]         wr_data_i,
    input  logic                        swap_req_i,
    output logic                        swap_done_o,
    output logic                        active_bank_o
);

    localparam int CSW = ch_sel_w(CH_NUM);
    localparam int DW  = CH_NUM * PX_WIDTH;

    logic          adv;
    logic          accept;
    logic          swap_now;
    logic          rd_bank;
    logic          byp_in;
    logic          active_bank;
    logic          pending;
    logic          p1_valid;
    logic          p1_user;
    logic          p1_last;
    logic          p1_byp;
    logic [DW-1:0] p1_raw;
    logic [DW-1:0] p1_map;

`ifdef IMG_LUT_BYPASS_EN
    assign byp_in = bypass_i;
`else
    assign byp_in = 1'b0;
`endif

    assign adv           = m_tready_i | ~m_tvalid_o;
    assign s_tready_o    = adv;
    assign accept        = s_tvalid_i & adv & ~rst_i;
    assign swap_now      = accept & s_tuser_i & (pending | swap_req_i);
    assign swap_done_o   = swap_now;
    assign active_bank_o = active_bank;
    // The swapping SOF beat already reads the bank that is about to become active.
    assign rd_bank       = active_bank ^ swap_now;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_en_i && (wr_ch_i == CSW'(c));

        img_lut_ram #(
            .ADDR_W(PX_WIDTH + 1),
            .DATA_W(PX_WIDTH)
        ) u_ram (
            .clk_i    (clk_i),
            .wr_en_i  (ch_wr),
            .wr_addr_i({~active_bank, wr_addr_i}),
            .wr_data_i(wr_data_i),
            .rd_en_i  (adv),
            .rd_addr_i({rd_bank, s_tdata_i[c*PX_WIDTH +: PX_WIDTH]}),
            .rd_data_o(p1_map[c*PX_WIDTH +: PX_WIDTH])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_bank <= 1'b0;
            pending     <= 1'b0;
            p1_valid    <= 1'b0;
            p1_user     <= 1'b0;
            p1_last     <= 1'b0;
            p1_byp      <= 1'b0;
            p1_raw      <= '0;
            m_tvalid_o  <= 1'b0;
            m_tuser_o   <= 1'b0;
            m_tlast_o   <= 1'b0;
            m_tdata_o   <= '0;
        end else begin
            if (swap_now) begin
                active_bank <= ~active_bank;
                pending     <= 1'b0;
            end else if (swap_req_i) begin
                pending <= 1'b1;
            end
            if (adv) begin
                p1_valid   <= s_tvalid_i;
                p1_user    <= s_tvalid_i & s_tuser_i;
                p1_last    <= s_tvalid_i & s_tlast_i;
                p1_byp     <= byp_in;
                p1_raw     <= s_tdata_i;
                m_tvalid_o <= p1_valid;
                m_tuser_o  <= p1_user;
                m_tlast_o  <= p1_last;
                m_tdata_o  <= p1_byp ? p1_raw : p1_map;
            end
        end
    end

endmodule
